// File: rtl/sync_fifo_wl.sv
// Single-clock FIFO with water level, almost-full/almost-empty thresholds, sticky error flags
// and either standard (registered, 1-cycle latency) or first-word-fall-through read mode.
module sync_fifo_wl #(
  parameter int DATA_WIDTH       = 16,
  parameter int DEPTH_WIDTH      = 11,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 1920,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_empty,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   water_level,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam logic [DEPTH_WIDTH:0]   CAP_LEVEL = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0]   AF_LEVEL  = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0]   AE_LEVEL  = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
  localparam logic [DEPTH_WIDTH:0]   ONE_LEVEL = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH-1:0] ONE_PTR   = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]  mem [2**DEPTH_WIDTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_WIDTH:0]   level_q, level_d, ram_level;
  logic [DATA_WIDTH-1:0]  rd_data_q;
  logic                   wr_full_q, almost_full_q, rd_empty_q, almost_empty_q;
  logic                   overflow_q, overflow_d, underflow_q, underflow_d;
  logic                   wr_acc, rd_acc, mem_we, mem_re, bypass, need_load;

  // In FWFT mode the output register holds the head word and counts toward the level, so the
  // RAM holds level minus one; a write into an otherwise empty FIFO skips the RAM entirely.
  always_comb begin
    rd_acc    = rd_en & ~rd_empty_q;
    wr_acc    = wr_en & (~wr_full_q | rd_acc);
    level_d   = level_q;
    if (wr_acc & ~rd_acc) begin
      level_d = level_q + ONE_LEVEL;
    end else if (~wr_acc & rd_acc) begin
      level_d = level_q - ONE_LEVEL;
    end
    ram_level = level_q - {{DEPTH_WIDTH{1'b0}}, ~rd_empty_q};
    need_load = rd_empty_q | rd_acc;
    if (FWFT != 0) begin
      mem_re = need_load & (ram_level != '0);
      bypass = need_load & (ram_level == '0) & wr_acc;
      mem_we = wr_acc & ~bypass;
    end else begin
      mem_re = rd_acc;
      bypass = 1'b0;
      mem_we = wr_acc;
    end
    overflow_d  = (wr_en & ~wr_acc) | (overflow_q & ~clr_err);
    underflow_d = (rd_en & ~rd_acc) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Read-before-write on the RAM keeps a simultaneous write/read at full from corrupting the head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      rd_data_q      <= '0;
      wr_full_q      <= 1'b0;
      almost_full_q  <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (mem_we) begin
        wr_ptr_q <= wr_ptr_q + ONE_PTR;
      end
      if (mem_re) begin
        rd_ptr_q  <= rd_ptr_q + ONE_PTR;
        rd_data_q <= mem[rd_ptr_q];
      end else if (bypass) begin
        rd_data_q <= wr_data;
      end
      level_q        <= level_d;
      wr_full_q      <= (level_d == CAP_LEVEL);
      almost_full_q  <= (level_d >= AF_LEVEL);
      rd_empty_q     <= (level_d == '0);
      almost_empty_q <= (level_d <= AE_LEVEL);
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign wr_full      = wr_full_q;
  assign almost_full  = almost_full_q;
  assign rd_data      = rd_data_q;
  assign rd_empty     = rd_empty_q;
  assign almost_empty = almost_empty_q;
  assign water_level  = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_wl.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and checks both
// every cycle against one queue-based model, plus hand-computed expectations.
module tb_sync_fifo_wl;

  localparam int DW  = 16;
  localparam int AW  = 11;
  localparam int CAP = 2048;
  localparam int AF  = 1920;
  localparam int AE  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN, wrEn, rdEn, clrErr;
  logic [DW-1:0] wrData;

  logic          sFull, sAf, sEmpty, sAe, sOvf, sUnf;
  logic [DW-1:0] sData;
  logic [AW:0]   sLevel;
  logic          fFull, fAf, fEmpty, fAe, fOvf, fUnf;
  logic [DW-1:0] fData;
  logic [AW:0]   fLevel;

  sync_fifo_wl #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(0),
                 .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)) dutStd (
    .clk(clk), .rst_n(rstN), .wr_en(wrEn), .wr_data(wrData), .wr_full(sFull),
    .almost_full(sAf), .rd_en(rdEn), .rd_data(sData), .rd_empty(sEmpty),
    .almost_empty(sAe), .water_level(sLevel), .overflow(sOvf), .underflow(sUnf),
    .clr_err(clrErr));

  sync_fifo_wl #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(1),
                 .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)) dutFwft (
    .clk(clk), .rst_n(rstN), .wr_en(wrEn), .wr_data(wrData), .wr_full(fFull),
    .almost_full(fAf), .rd_en(rdEn), .rd_data(fData), .rd_empty(fEmpty),
    .almost_empty(fAe), .water_level(fLevel), .overflow(fOvf), .underflow(fUnf),
    .clr_err(clrErr));

  logic [DW-1:0] mq[$];
  logic [DW-1:0] mStd;
  bit            mOvf, mUnf, modelReady;
  int            passCount = 0;
  int            checkCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model: the FIFO contents as a queue; an accepted read pops the head, an accepted write appends.
  always @(posedge clk) begin : model
    bit rdA, wrA;
    if (!rstN) begin
      mq.delete();
      mOvf = 0;
      mUnf = 0;
      mStd = '0;
      modelReady = 1;
    end else begin
      rdA = rdEn && (mq.size() > 0);
      wrA = wrEn && ((mq.size() < CAP) || rdA);
      if (wrEn && !wrA) mOvf = 1;
      else if (clrErr) mOvf = 0;
      if (rdEn && !rdA) mUnf = 1;
      else if (clrErr) mUnf = 0;
      if (rdA) mStd = mq.pop_front();
      if (wrA) mq.push_back(wrData);
    end
  end

  // Both instances share every flag with the model; only rd_data differs between the modes.
  always @(negedge clk) begin : compare
    int lvl;
    if (modelReady) begin
      lvl = mq.size();
      checkOutput("s_level",    32'(sLevel), 32'(lvl));
      checkOutput("f_level",    32'(fLevel), 32'(lvl));
      checkOutput("s_wr_full",  32'(sFull),  32'(lvl == CAP));
      checkOutput("f_wr_full",  32'(fFull),  32'(lvl == CAP));
      checkOutput("s_afull",    32'(sAf),    32'(lvl >= AF));
      checkOutput("f_afull",    32'(fAf),    32'(lvl >= AF));
      checkOutput("s_rd_empty", 32'(sEmpty), 32'(lvl == 0));
      checkOutput("f_rd_empty", 32'(fEmpty), 32'(lvl == 0));
      checkOutput("s_aempty",   32'(sAe),    32'(lvl <= AE));
      checkOutput("f_aempty",   32'(fAe),    32'(lvl <= AE));
      checkOutput("s_overflow", 32'(sOvf),   32'(mOvf));
      checkOutput("f_overflow", 32'(fOvf),   32'(mOvf));
      checkOutput("s_underflow", 32'(sUnf),  32'(mUnf));
      checkOutput("f_underflow", 32'(fUnf),  32'(mUnf));
      checkOutput("s_rd_data",  32'(sData),  32'(mStd));
      if (lvl > 0) checkOutput("f_rd_data", 32'(fData), 32'(mq[0]));
    end
  end

  task automatic applyStimulus(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    wrEn   = w;
    wrData = d;
    rdEn   = r;
    clrErr = c;
    @(posedge clk);
    #1;
    wrEn   = 0;
    rdEn   = 0;
    clrErr = 0;
  endtask

  initial begin
    rstN = 0; wrEn = 0; rdEn = 0; clrErr = 0; wrData = '0;
    applyStimulus(0, '0, 0, 0);
    applyStimulus(0, '0, 0, 0);
    rstN = 1;
    checkOutput("lit_reset_level", 32'(sLevel), 32'd0);
    checkOutput("lit_reset_empty", 32'(fEmpty), 32'd1);
    checkOutput("lit_reset_data",  32'(sData),  32'd0);

    // Fill to capacity; almost_full must rise exactly with the 1920th write.
    for (int i = 0; i < CAP; i++) begin
      applyStimulus(1, DW'(i), 0, 0);
      if (i == 1918) checkOutput("lit_afull_1919", 32'(sAf), 32'd0);
      if (i == 1919) checkOutput("lit_afull_1920", 32'(fAf), 32'd1);
    end
    checkOutput("lit_full",       32'(sFull),  32'd1);
    checkOutput("lit_full_level", 32'(fLevel), 32'd2048);
    applyStimulus(1, 16'hFFFF, 0, 0);
    checkOutput("lit_overflow",      32'(sOvf),   32'd1);
    checkOutput("lit_overflow_lvl",  32'(sLevel), 32'd2048);

    // Full with simultaneous write/read, then drain everything in order.
    applyStimulus(0, '0, 0, 1);
    checkOutput("lit_ovf_cleared", 32'(fOvf), 32'd0);
    applyStimulus(1, DW'(CAP), 1, 0);
    checkOutput("lit_fullrw_level", 32'(sLevel), 32'd2048);
    checkOutput("lit_fullrw_full",  32'(sFull),  32'd1);
    checkOutput("lit_fullrw_ovf",   32'(sOvf),   32'd0);
    checkOutput("lit_fullrw_data",  32'(sData),  32'd0);
    for (int i = 1; i <= CAP; i++) begin
      applyStimulus(0, '0, 1, 0);
      if (i == CAP) checkOutput("lit_drain_last", 32'(sData), 32'(CAP));
    end
    checkOutput("lit_drained", 32'(sEmpty), 32'd1);

    // Empty with simultaneous write/read: the read is rejected.
    applyStimulus(1, 16'h1234, 1, 0);
    checkOutput("lit_underflow",     32'(sUnf),   32'd1);
    checkOutput("lit_underflow_lvl", 32'(fLevel), 32'd1);
    checkOutput("lit_fwft_1234",     32'(fData),  32'h1234);
    applyStimulus(0, '0, 0, 1);
    checkOutput("lit_unf_cleared", 32'(sUnf), 32'd0);
    applyStimulus(0, '0, 1, 0);

    // Level sweep across the almost_empty threshold.
    for (int l = 0; l <= 6; l++) begin
      checkOutput("lit_sweep_level", 32'(sLevel), 32'(l));
      checkOutput("lit_sweep_aempty", 32'(fAe), (l <= 4) ? 32'd1 : 32'd0);
      applyStimulus(1, DW'(16'h0C00 + l), 0, 0);
    end
    for (int l = 0; l < 7; l++) applyStimulus(0, '0, 1, 0);

    // FWFT: head word visible before rd_en, then eight reads with no bubble.
    applyStimulus(1, 16'hA5A5, 0, 0);
    checkOutput("lit_fwft_empty", 32'(fEmpty), 32'd0);
    checkOutput("lit_fwft_a5a5",  32'(fData),  32'hA5A5);
    for (int k = 1; k < 8; k++) applyStimulus(1, DW'(16'hB000 + k), 0, 0);
    for (int k = 0; k < 8; k++) begin
      checkOutput("lit_fwft_stream", 32'(fData), (k == 0) ? 32'hA5A5 : 32'(16'hB000 + k));
      checkOutput("lit_fwft_nobubble", 32'(fEmpty), 32'd0);
      applyStimulus(0, '0, 1, 0);
    end

    // Reset with 100 words held; only post-reset data may come out afterwards.
    for (int i = 0; i < 100; i++) applyStimulus(1, DW'(16'h5000 + i), 0, 0);
    checkOutput("lit_level_100", 32'(sLevel), 32'd100);
    rstN = 0;
    applyStimulus(1, 16'hDEAD, 1, 0);
    rstN = 1;
    checkOutput("lit_mid_rst_level", 32'(fLevel), 32'd0);
    checkOutput("lit_mid_rst_empty", 32'(sEmpty), 32'd1);
    checkOutput("lit_mid_rst_data",  32'(sData),  32'd0);
    for (int k = 0; k < 3; k++) applyStimulus(1, DW'(16'h7000 + k), 0, 0);
    checkOutput("lit_refill_head", 32'(fData), 32'h7000);
    applyStimulus(0, '0, 1, 0);
    checkOutput("lit_refill_read", 32'(sData), 32'h7000);

    // Random traffic: write-biased then read-biased, with occasional clears and resets.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) == 0) rstN = 0;
      applyStimulus(($urandom_range(0, 99) < ((n < 2000) ? 70 : 35)), DW'($urandom),
                    ($urandom_range(0, 99) < ((n < 2000) ? 35 : 70)),
                    ($urandom_range(0, 49) == 0));
      rstN = 1;
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
